// File: rtl/bch_bm_arbiter_pkg.sv
// ============================================================================
// Module : bch_bm_arbiter_pkg
// Brief  : Code parameters, FSM state and lane tag types shared by the
//          Berlekamp-Massey engine arbiter (t=10 over GF(2^7)).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bch_bm_arbiter_pkg;

  localparam int c_GF_M   = 7;
  localparam int c_DATA_W = c_GF_M;
  localparam int c_T      = 10;
  localparam int c_T2     = 2 * c_T;
  localparam int c_SYN_W  = c_T2 * c_DATA_W;
  localparam int c_POLY_W = (c_T + 1) * c_DATA_W;

  typedef logic [c_DATA_W-1:0] data_t;
  typedef logic                tag_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/bch_bm_arb_rr.sv
// ============================================================================
// Module : bch_bm_arb_rr
// Brief  : Two-way round-robin grant; when both lanes request, the lane that
//          was not served last wins. Pointer resets to favour lane 0.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bch_bm_arb_rr
  import bch_bm_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clkena,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  tag_t       i_served,
  output logic       o_any,
  output tag_t       o_grant
);

  tag_t r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_clkena && i_update) begin
      r_last <= i_served;
    end
  end

  always_comb begin
    o_any   = |i_req;
    o_grant = 1'b0;
    if (i_req == 2'b11) begin
      o_grant = ~r_last;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bch_bm_arbiter.sv
// ============================================================================
// Module : bch_bm_arbiter
// Brief  : Shares one Berlekamp-Massey engine between two syndrome lanes with
//          per-lane frame buffers, round-robin grant, tagged result and a
//          watchdog that flushes a silent engine.
//          Optional macro BCH_BM_ARB_STAT_EN adds per-lane decfail counters.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bch_bm_arbiter
  import bch_bm_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic [1:0]          isyndrome_val,
  input  logic [c_SYN_W-1:0]  isyndrome0,
  input  logic [c_SYN_W-1:0]  isyndrome1,
  output logic [1:0]          ordy,
  output logic                oeng_syn_val,
  output logic [c_SYN_W-1:0]  oeng_syndrome,
  output logic                oeng_flush,
  input  logic                ieng_poly_val,
  input  logic [c_POLY_W-1:0] ieng_poly,
  input  data_t               ieng_poly_deg,
  input  logic                ieng_decfail,
  output logic                oloc_poly_val,
  output logic [c_POLY_W-1:0] oloc_poly,
  output data_t               oloc_poly_deg,
  output logic                oloc_decfail,
  output logic                otag,
  output logic                otimeout
`ifdef BCH_BM_ARB_STAT_EN
  ,
  output logic [CNT_W-1:0]    odecfail_cnt0,
  output logic [CNT_W-1:0]    odecfail_cnt1
`endif
);

  localparam int                 c_WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [1:0]          r_full;
  logic [c_SYN_W-1:0]  r_buf0;
  logic [c_SYN_W-1:0]  r_buf1;
  logic [c_SYN_W-1:0]  r_eng_syn;
  tag_t                r_grant;
  logic [c_WD_W-1:0]   r_wd;
  logic [c_POLY_W-1:0] r_loc_poly;
  data_t               r_loc_deg;
  logic                r_loc_decfail;
  tag_t                r_tag;
  logic                r_timeout;

  logic       w_start;
  logic       w_wait;
  logic       w_done;
  logic       w_flush;
  logic       w_wd_expired;
  logic       w_any;
  tag_t       w_grant;
  logic [1:0] w_take;
  logic [1:0] w_free;

  bch_bm_arb_rr u_rr (
    .clk      (iclk),
    .rst_n    (ireset),
    .i_clkena (iclkena),
    .i_req    (r_full),
    .i_update (w_done),
    .i_served (r_grant),
    .o_any    (w_any),
    .o_grant  (w_grant)
  );

  assign w_wd_expired = (r_wd == c_WD_LAST);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_state <= S_IDLE;
    end else if (iclkena) begin
      r_state <= w_next;
    end
  end

  // An engine answer in the expiry cycle is taken as a real result.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_wait  = 1'b0;
    w_done  = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_START;
      end
      S_START: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        w_wait = 1'b1;
        if (ieng_poly_val) begin
          w_next = S_DONE;
        end else if (w_wd_expired) begin
          w_flush = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_take = isyndrome_val & ~r_full;
  assign w_free = {w_done & r_grant, w_done & ~r_grant};

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_full <= 2'b00;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (iclkena) begin
      r_full <= (r_full | w_take) & ~w_free;
      if (w_take[0]) r_buf0 <= isyndrome0;
      if (w_take[1]) r_buf1 <= isyndrome1;
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_grant   <= 1'b0;
      r_eng_syn <= '0;
      r_wd      <= '0;
    end else if (iclkena) begin
      if (r_state == S_IDLE && w_any) begin
        r_grant   <= w_grant;
        r_eng_syn <= w_grant ? r_buf1 : r_buf0;
      end
      if (w_start) begin
        r_wd <= '0;
      end else if (w_wait && !w_wd_expired) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_loc_poly    <= '0;
      r_loc_deg     <= '0;
      r_loc_decfail <= 1'b0;
      r_tag         <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (iclkena) begin
      if (w_wait && ieng_poly_val) begin
        r_loc_poly    <= ieng_poly;
        r_loc_deg     <= ieng_poly_deg;
        r_loc_decfail <= ieng_decfail;
        r_tag         <= r_grant;
        r_timeout     <= 1'b0;
      end else if (w_flush) begin
        r_loc_poly    <= '0;
        r_loc_deg     <= '0;
        r_loc_decfail <= 1'b1;
        r_tag         <= r_grant;
        r_timeout     <= 1'b1;
      end
    end
  end

`ifdef BCH_BM_ARB_STAT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (iclkena && w_done && r_loc_decfail) begin
      if (r_tag) begin
        if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
      end else begin
        if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
      end
    end
  end

  assign odecfail_cnt0 = r_cnt0;
  assign odecfail_cnt1 = r_cnt1;
`endif

  assign ordy          = ~r_full;
  assign oeng_syn_val  = w_start;
  assign oeng_syndrome = r_eng_syn;
  assign oeng_flush    = w_flush;
  assign oloc_poly_val = w_done;
  assign oloc_poly     = r_loc_poly;
  assign oloc_poly_deg = r_loc_deg;
  assign oloc_decfail  = r_loc_decfail;
  assign otag          = r_tag;
  assign otimeout      = w_done & r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bch_bm_arbiter.sv
// ============================================================================
// Module : tb_bch_bm_arbiter
// Brief  : Scoreboard bench for bch_bm_arbiter with a stub BM engine whose
//          answer is a fixed function of the syndromes it is handed.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bch_bm_arbiter;
  import bch_bm_arbiter_pkg::*;

  localparam int TIMEOUT = 256;
  localparam int CNT_W   = 16;

  typedef int vec20_t[20];
  typedef struct {
    logic                tag;
    logic [c_POLY_W-1:0] poly;
    logic [6:0]          deg;
    logic                decfail;
    logic                tmo;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n, clkena;
  logic [1:0]          syn_val;
  logic [c_SYN_W-1:0]  syn0, syn1;
  logic [1:0]          ordy;
  logic                eng_syn_val, eng_flush;
  logic [c_SYN_W-1:0]  eng_syndrome;
  logic                eng_val, eng_fail;
  logic [c_POLY_W-1:0] eng_poly;
  logic [6:0]          eng_deg;
  logic                loc_val, loc_fail, tag, tmo;
  logic [c_POLY_W-1:0] loc_poly;
  logic [6:0]          loc_deg;
`ifdef BCH_BM_ARB_STAT_EN
  logic [CNT_W-1:0]    cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  bch_bm_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .iclk          (clk),
    .ireset        (rst_n),
    .iclkena       (clkena),
    .isyndrome_val (syn_val),
    .isyndrome0    (syn0),
    .isyndrome1    (syn1),
    .ordy          (ordy),
    .oeng_syn_val  (eng_syn_val),
    .oeng_syndrome (eng_syndrome),
    .oeng_flush    (eng_flush),
    .ieng_poly_val (eng_val),
    .ieng_poly     (eng_poly),
    .ieng_poly_deg (eng_deg),
    .ieng_decfail  (eng_fail),
    .oloc_poly_val (loc_val),
    .oloc_poly     (loc_poly),
    .oloc_poly_deg (loc_deg),
    .oloc_decfail  (loc_fail),
    .otag          (tag),
    .otimeout      (tmo)
`ifdef BCH_BM_ARB_STAT_EN
    ,
    .odecfail_cnt0 (cnt0),
    .odecfail_cnt1 (cnt1)
`endif
  );

  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, n_starts = 0, n_results = 0;
  int   last_start_cyc = 0, last_done_cyc = 0;
  int   flush_exp = 0, eng_lat = 4, stray_cnt = 0;
  bit   eng_silent = 1'b0, chk_gap = 1'b0;
  exp_t sb[$];

  vec20_t vA0 = '{45,73,121,13,98,7,66,101,30,88,54,19,112,3,77,60,91,27,120,75};
  vec20_t vB0 = '{110,44,9,87,23,64,118,35,71,2,99,50,14,83,126,40,61,5,97,116};
  vec20_t vB1 = '{15,85,33,120,6,72,101,58,27,90,11,66,124,39,80,18,47,103,62,39};
  vec20_t vC0 = '{3,6,9,12,15,18,21,24,27,30,33,36,39,42,45,48,51,54,57,60};
  vec20_t vD0 = '{127,126,125,124,123,122,121,120,119,118,117,116,115,114,113,112,111,110,109,108};
  vec20_t vD1 = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18,19};
  vec20_t vE0 = '{8,16,24,32,40,48,56,64,72,80,88,96,104,112,120,1,9,17,25,33};
  vec20_t vE1 = '{50,51,52,53,54,55,56,57,58,59,60,61,62,63,64,65,66,67,68,69};
  vec20_t vF1 = '{64,32,16,8,4,2,1,65,33,17,9,5,3,66,34,18,10,6,68,36};
  vec20_t vG0 = '{9,8,7,6,5,4,3,2,1,0,10,20,30,40,50,60,70,80,90,100};
  vec20_t vH0 = '{99,98,97,96,95,94,93,92,91,90,89,88,87,86,85,84,83,82,81,80};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [c_SYN_W-1:0] pack(input vec20_t v);
    logic [c_SYN_W-1:0] s = '0;
    for (int k = 0; k < 20; k++) s[k*7 +: 7] = 7'(v[k]);
    return s;
  endfunction

  // Stub engine answer: poly[i] = S(i+1)^0x55, deg = S1 mod 11, decfail = lsb of S2.
  function automatic exp_t model(input logic ln, input logic [c_SYN_W-1:0] s, input bit to);
    exp_t e;
    e.tag = ln; e.tmo = to; e.poly = '0; e.deg = '0; e.decfail = 1'b1;
    if (!to) begin
      for (int i = 0; i <= 10; i++) e.poly[i*7 +: 7] = s[i*7 +: 7] ^ 7'h55;
      e.deg     = 7'(s[6:0] % 7'd11);
      e.decfail = s[7];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  initial begin : eng_stub
    logic [c_SYN_W-1:0] s;
    exp_t r;
    int   seen;
    seen = 0;
    eng_val = 1'b0; eng_poly = '0; eng_deg = '0; eng_fail = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_cnt != seen) begin
        seen = stray_cnt;
        eng_poly = '1; eng_deg = 7'd3; eng_val = 1'b1;
        @(negedge clk);
        eng_val = 1'b0;
      end else if (eng_syn_val && !eng_silent) begin
        s = eng_syndrome;
        repeat (eng_lat) @(negedge clk);
        r = model(1'b0, s, 1'b0);
        eng_poly = r.poly; eng_deg = r.deg; eng_fail = r.decfail; eng_val = 1'b1;
        @(negedge clk);
        eng_val = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (eng_syn_val) begin
      n_starts++;
      last_start_cyc = cyc;
      if (chk_gap) begin
        check("start_after_done_gap", cyc - last_done_cyc, 2);
        chk_gap = 1'b0;
      end
    end
    if (eng_flush) begin
      check("flush_expected", (flush_exp > 0), 1);
      check("flush_cycle_after_start", cyc - last_start_cyc, TIMEOUT);
      if (flush_exp > 0) flush_exp--;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (loc_val) begin
        n_results++;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result: got tag %0d poly 0x%0h, expected no result", tag, loc_poly);
        end else begin
          e = sb.pop_front();
          check("res_tag", tag, e.tag);
          check("res_poly", loc_poly, e.poly);
          check("res_deg", loc_deg, e.deg);
          check("res_decfail", loc_fail, e.decfail);
          check("res_timeout", tmo, e.tmo);
          @(negedge clk);
          check("ordy_reopen", ordy[e.tag], 1);
        end
      end
    end
  end

  task automatic send(input logic ln, input vec20_t v);
    check("ordy_before_send", ordy[ln], 1);
    if (ln) syn1 = pack(v); else syn0 = pack(v);
    syn_val[ln] = 1'b1;
    @(negedge clk);
    syn_val = 2'b00;
    check("ordy_drop", ordy[ln], 0);
  endtask

  task automatic send_both(input vec20_t v0, input vec20_t v1);
    syn0 = pack(v0); syn1 = pack(v1); syn_val = 2'b11;
    @(negedge clk);
    syn_val = 2'b00;
    check("ordy_drop_both", ordy, 2'b00);
  endtask

  task automatic wait_results(input int target);
    int budget = 0;
    while (n_results < target && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (n_results < target) check("result_wait_timeout", n_results, target);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input int base);
    int budget = 0;
    while (n_starts <= base && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (n_starts <= base) check("start_wait_timeout", n_starts, base + 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    int base;
    rst_n = 1'b0; clkena = 1'b1; syn_val = 2'b00; syn0 = '0; syn1 = '0;
    repeat (3) @(negedge clk);
    check("rst_ordy", ordy, 2'b11);
    check("rst_syn_val", eng_syn_val, 0);
    check("rst_loc_val", loc_val, 0);
    check("rst_flush", eng_flush, 0);
    check("rst_tag", tag, 0);
    check("rst_poly", loc_poly, 0);
    check("rst_eng_syndrome", eng_syndrome, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone lane-0 frame
    base = n_starts;
    sb.push_back(model(1'b0, pack(vA0), 1'b0));
    send(1'b0, vA0);
    wait_results(1);
    check("single_start_count", n_starts - base, 1);

    // Simultaneous pair from reset: lane 0 first
    do_reset();
    sb.push_back(model(1'b0, pack(vB0), 1'b0));
    sb.push_back(model(1'b1, pack(vB1), 1'b0));
    send_both(vB0, vB1);
    wait_results(3);
    // Lane 0 served last, so the next pair starts with lane 1
    sb.push_back(model(1'b0, pack(vC0), 1'b0));
    send(1'b0, vC0);
    wait_results(4);
    sb.push_back(model(1'b1, pack(vD1), 1'b0));
    sb.push_back(model(1'b0, pack(vD0), 1'b0));
    send_both(vD0, vD1);
    wait_results(6);

    // Lane 1 arrives while lane 0 is waiting on a slow engine
    eng_lat = 20;
    base = n_starts;
    sb.push_back(model(1'b0, pack(vE0), 1'b0));
    sb.push_back(model(1'b1, pack(vE1), 1'b0));
    send(1'b0, vE0);
    wait_start(base);
    repeat (5) @(negedge clk);
    chk_gap = 1'b1;
    send(1'b1, vE1);
    wait_results(8);

    // Silent engine: three watchdog timeouts on lane 1
    do_reset();
`ifdef BCH_BM_ARB_STAT_EN
    check("stat_cnt0_reset", cnt0, 0);
    check("stat_cnt1_reset", cnt1, 0);
`endif
    eng_silent = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush_exp = 1;
      sb.push_back(model(1'b1, pack(vF1), 1'b1));
      send(1'b1, vF1);
      wait_results(9 + i);
      check("flush_seen", flush_exp, 0);
    end
`ifdef BCH_BM_ARB_STAT_EN
    check("stat_cnt1_timeouts", cnt1, 3);
    check("stat_cnt0_untouched", cnt0, 0);
`endif

    // Answer lands in the watchdog's last cycle: result wins, no flush
    eng_silent = 1'b0;
    eng_lat = TIMEOUT;
    sb.push_back(model(1'b0, pack(vG0), 1'b0));
    send(1'b0, vG0);
    wait_results(12);
    eng_lat = 4;

    // Stray engine strobe in IDLE
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("stray_no_result", n_results, 12);

    // Asynchronous reset while waiting
    eng_silent = 1'b1;
    base = n_starts;
    send(1'b0, vH0);
    wait_start(base);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ordy", ordy, 2'b11);
    check("async_rst_loc_val", loc_val, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("async_rst_no_result", n_results, 12);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
